// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and load-sanitising helper for the BCD down-counter.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Non-BCD nibbles (0xA-0xF) become 9 when clamping, 0 otherwise.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t n, input bit clamp);
    if (n > BCD_MAX) begin
      return clamp ? BCD_MAX : BCD_MIN;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the BCD down-counter: states 0..9, decrements on borrow_in, 0 -> 9 on borrow.
// q is the digit state and doubles as its observation point.
module bcd_down_digit
  import bcd_pkg::*;
#(
  parameter int LOAD_CLAMP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       borrow_in,
  output bcd_digit_t q,
  output logic       is_zero
);

  bcd_digit_t q_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= BCD_MIN;
    end else begin
      q <= q_next;
    end
  end

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = bcd_sanitize(load_digit, LOAD_CLAMP != 0);
    end else if (borrow_in) begin
      q_next = (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign is_zero = (q == BCD_MIN);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down-counter with a ripple-free borrow chain and cascade output tc.
// Define BCD_HOLD_AT_ZERO_EN to saturate at all-zero instead of wrapping to all-nines.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int LOAD_CLAMP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                zero,
  output logic                tc
);

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] borrow;
  logic              count_en;

`ifdef BCD_HOLD_AT_ZERO_EN
  assign count_en = en & ~load & ~zero;
`else
  assign count_en = en & ~load;
`endif

  // Digit k borrows only when every lower digit is already 0; all digits update together.
  always_comb begin
    borrow    = '0;
    borrow[0] = count_en;
    for (int k = 1; k < DIGITS; k++) begin
      borrow[k] = borrow[k-1] & is_zero[k-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit #(
      .LOAD_CLAMP(LOAD_CLAMP)
    ) u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_digit(load_val[g*BCD_W +: BCD_W]),
      .borrow_in (borrow[g]),
      .q         (bcd_out[g*BCD_W +: BCD_W]),
      .is_zero   (is_zero[g])
    );
  end

  assign zero = &is_zero;
  assign tc   = en & zero & ~load;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: two cascaded 2-digit instances (low clamps loads, high zeroes them)
// checked against a decimal-integer model through an expected-state queue.
module tb_bcd_down_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load_lo = 1'b0;
  logic       load_hi = 1'b0;
  logic [7:0] lv_lo = 8'h00;
  logic [7:0] lv_hi = 8'h00;
  logic [7:0] bcd_lo, bcd_hi;
  logic       zero_lo, zero_hi, tc_lo, tc_hi;

  int checks = 0;
  int failures = 0;

  logic [17:0] exp_q[$];

  // Model state: each instance's count as a plain decimal integer 0..99.
  int m_lo = 0;
  int m_hi = 0;
  bit m_valid = 1'b0;

`ifdef BCD_HOLD_AT_ZERO_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .LOAD_CLAMP(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load_lo), .load_val(lv_lo),
    .bcd_out(bcd_lo), .zero(zero_lo), .tc(tc_lo)
  );

  bcd_down_counter #(.DIGITS(2), .LOAD_CLAMP(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(tc_lo), .load(load_hi), .load_val(lv_hi),
    .bcd_out(bcd_hi), .zero(zero_hi), .tc(tc_hi)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int nib(input logic [3:0] n, input bit clamp);
    if (n > 4'd9) return clamp ? 9 : 0;
    return int'(n);
  endfunction

  function automatic int load_dec(input logic [7:0] v, input bit clamp);
    return nib(v[7:4], clamp) * 10 + nib(v[3:0], clamp);
  endfunction

  function automatic int count_down(input int v);
    if (v == 0) return HOLD ? 0 : 99;
    return v - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: one clock cycle of stimulus, tc checked combinationally, next state queued
  task automatic step(input bit r, input bit e, input bit ll, input logic [7:0] vl,
                      input bit lh, input logic [7:0] vh);
    bit etl, eth;
    int nl, nh;
    @(negedge clk);
    rst_n = r; en = e; load_lo = ll; lv_lo = vl; load_hi = lh; lv_hi = vh;
    #1;
    etl = e && (m_lo == 0) && !ll;
    eth = etl && (m_hi == 0) && !lh;
    if (m_valid) begin
      check("tc_lo", {31'd0, tc_lo}, {31'd0, etl});
      check("tc_hi", {31'd0, tc_hi}, {31'd0, eth});
    end
    if (!r) begin
      m_lo = 0; m_hi = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      nl = ll ? load_dec(vl, 1'b1) : (e ? count_down(m_lo) : m_lo);
      nh = lh ? load_dec(vh, 1'b0) : (etl ? count_down(m_hi) : m_hi);
      m_lo = nl; m_hi = nh;
    end
    if (m_valid) exp_q.push_back({to_bcd(m_hi), to_bcd(m_lo), m_hi == 0, m_lo == 0});
  endtask

  // scoreboard monitor: one queued expectation per clock edge
  always @(posedge clk) begin
    logic [17:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state", {14'd0, bcd_hi, bcd_lo, zero_hi, zero_lo}, {14'd0, e});
    end
  end

  initial begin
    // reset overrides load and en
    step(0, 1, 1, 8'h57, 1, 8'h57);
    step(0, 1, 1, 8'h57, 1, 8'h57);
    step(1, 0, 0, 8'h00, 0, 8'h00);
    // load 12 then count through the digit-1 borrow
    step(1, 0, 1, 8'h12, 0, 8'h00);
    repeat (3) step(1, 1, 0, 8'h00, 0, 8'h00);
    // wrap (or hold) at zero
    step(1, 0, 1, 8'h01, 1, 8'h05);
    repeat (2) step(1, 1, 0, 8'h00, 0, 8'h00);
    // load beats en
    step(1, 0, 1, 8'h30, 0, 8'h00);
    step(1, 1, 1, 8'h45, 0, 8'h00);
    // non-BCD load nibbles: clamp on low instance, zero on high
    step(1, 0, 1, 8'hA3, 1, 8'hA3);
    step(1, 0, 1, 8'hFF, 1, 8'h3C);
    // cascade borrow across instances
    step(1, 0, 1, 8'h00, 1, 8'h01);
    step(1, 1, 0, 8'h00, 0, 8'h00);
    // reset mid-count
    step(1, 0, 1, 8'h55, 1, 8'h22);
    step(1, 1, 0, 8'h00, 0, 8'h00);
    step(0, 1, 0, 8'h00, 0, 8'h00);
    step(1, 1, 0, 8'h00, 0, 8'h00);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 11) == 0, 8'($urandom_range(0, 255)));
    end
    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
